// File: rtl/ahb_cfg_arb.sv
// Two-requester arbiter with a single-transfer AHB-Lite master port for the
// tdm register bank: one NONSEQ word transfer at a time, with done/err/rdata per requester.
module ahb_cfg_arb #(
  parameter int PRIORITY = 0,
  parameter int TIMEOUT  = 256
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        req0,
  input  logic        wr0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        done0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic        wr1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        done1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        hsel,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic        hmastlock,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        rr_q, rr_d;          // requester favoured when both request
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        win, finish, fin_err, fin_load;

  assign win = (req0 && req1) ? ((PRIORITY != 0) ? 1'b0 : rr_q) : req1;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hwdata_d = hwdata_q;
    cnt_d    = cnt_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = err0_q;
    err1_d   = err1_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    finish   = 1'b0;
    fin_err  = 1'b0;
    fin_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The cycle carrying a done pulse is never an arbitration cycle, so a
        // requester that drops req on seeing done is not served twice.
        if ((req0 || req1) && !(done0_q || done1_q)) begin
          state_d = S_ADDR;
          grant_d = win;
          rr_d    = ~win;
          wr_d    = win ? wr1 : wr0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (hready) begin
          state_d  = S_DATA;
          cnt_d    = '0;
          hwdata_d = wdata_q;
        end else if (cnt_q == TO_LAST) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (hready) begin
          finish   = 1'b1;
          fin_err  = (hresp != 2'b00);
          fin_load = !wr_q;
        end else if (cnt_q == TO_LAST) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d = S_IDLE;
      if (grant_q) begin
        done1_d = 1'b1;
        err1_d  = fin_err;
        if (fin_load) rdata1_d = hrdata;
      end else begin
        done0_d = 1'b1;
        err0_d  = fin_err;
        if (fin_load) rdata0_d = hrdata;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      cnt_q    <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hwdata_q <= hwdata_d;
      cnt_q    <= cnt_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign hsel      = (state_q == S_ADDR);
  assign htrans    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign haddr     = addr_q;
  assign hwrite    = wr_q;
  assign hsize     = 3'b010;
  assign hburst    = 3'b000;
  assign hmastlock = 1'b0;
  assign hwdata    = hwdata_q;
  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_ahb_cfg_arb.sv
// Bench for ahb_cfg_arb: transaction-level model of arbitration order, transfer
// latency, slave wait/error/hang behaviour and per-requester result registers.
module tb_ahb_cfg_arb;

  localparam int TO     = 8;
  localparam int K_OK   = 0;
  localparam int K_ERR  = 1;
  localparam int K_HANG = 2;

  typedef struct {
    bit          who;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aw;    // address-phase wait states
    int          dw;    // data-phase low cycles before the final hready=1 cycle
    int          kind;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        req0, wr0, req1, wr1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        done0, err0, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic        hsel, hwrite, hmastlock, grant, busy;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;
  logic        hready;

  logic        p_req0, p_req1;
  logic        p_done0, p_err0, p_done1, p_err1;
  logic [31:0] p_rdata0, p_rdata1, p_haddr, p_hwdata;
  logic        p_hsel, p_hwrite, p_hmastlock, p_grant, p_busy;
  logic [1:0]  p_htrans;
  logic [2:0]  p_hsize, p_hburst;

  always #5 hclk = ~hclk;

  ahb_cfg_arb #(.PRIORITY(0), .TIMEOUT(TO)) u_dut (
    .hclk(hclk), .hresetn(hresetn),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .grant(grant), .busy(busy)
  );

  ahb_cfg_arb #(.PRIORITY(1)) u_pri (
    .hclk(hclk), .hresetn(hresetn),
    .req0(p_req0), .wr0(1'b1), .addr0(32'h10), .wdata0(32'h1),
    .done0(p_done0), .rdata0(p_rdata0), .err0(p_err0),
    .req1(p_req1), .wr1(1'b0), .addr1(32'h20), .wdata1(32'h2),
    .done1(p_done1), .rdata1(p_rdata1), .err1(p_err1),
    .hsel(p_hsel), .haddr(p_haddr), .htrans(p_htrans), .hwrite(p_hwrite),
    .hsize(p_hsize), .hburst(p_hburst), .hmastlock(p_hmastlock), .hwdata(p_hwdata),
    .hrdata(32'h0), .hready(1'b1), .hresp(2'b00),
    .grant(p_grant), .busy(p_busy)
  );

  int          total = 0;
  int          bad   = 0;
  bit          last_grant;
  bit          exp_err [2];
  logic [31:0] exp_rdata [2];
  xfer_t       xq0[$];
  xfer_t       xq1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input bit who, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int aw, input int dw, input int kind);
    xfer_t x;
    x.who = who; x.wr = wr; x.addr = addr; x.wdata = wdata; x.rdata = rdata;
    x.aw = aw; x.dw = dw; x.kind = kind;
    return x;
  endfunction

  function automatic xfer_t rand_xfer(input bit who);
    int r;
    int k;
    r = int'($urandom_range(0, 9));
    k = (r == 0) ? K_HANG : (r <= 2) ? K_ERR : K_OK;
    // A two-cycle ERROR response occupies at least one low data cycle.
    return mk(who, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)) + ((k == K_ERR) ? 1 : 0), k);
  endfunction

  task automatic set_fields(input bit who, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (who) begin wr1 = w; addr1 = a; wdata1 = d; end
    else     begin wr0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic set_req(input bit who, input bit r);
    if (who) req1 = r; else req0 = r;
  endtask

  // Entered at the negedge of an arbitration cycle with the request driven;
  // returns at the negedge of the done cycle.
  task automatic run_xfer(input xfer_t x, input bit may_drop);
    int ndata;
    check("idle_ctl",  32'({busy, hsel, htrans}), 32'h0);
    check("idle_done", 32'({done1, done0}), 32'h0);
    hready = 1'($urandom_range(0, 1));
    hresp  = 2'($urandom_range(0, 1));
    hrdata = $urandom;
    @(negedge hclk);
    for (int i = 0; i <= x.aw; i++) begin
      check("addr_ctl",  32'({hsel, htrans, hwrite, busy, grant}),
                         32'({1'b1, 2'b10, x.wr, 1'b1, x.who}));
      check("haddr",     haddr, x.addr);
      check("addr_done", 32'({done1, done0}), 32'h0);
      if (i == 0) set_fields(x.who, 1'($urandom_range(0, 1)), $urandom, $urandom);
      hready = (i == x.aw);
      hresp  = 2'b00;
      hrdata = $urandom;
      @(negedge hclk);
    end
    ndata = (x.kind == K_HANG) ? TO : x.dw + 1;
    for (int j = 0; j < ndata; j++) begin
      check("data_ctl",  32'({hsel, htrans, busy}), 32'({1'b0, 2'b00, 1'b1}));
      check("data_done", 32'({done1, done0}), 32'h0);
      if (x.wr && j == 0) check("hwdata", hwdata, x.wdata);
      if (may_drop && j == 0 && $urandom_range(0, 3) == 0) set_req(x.who, 1'b0);
      hready = (x.kind != K_HANG) && (j == ndata - 1);
      hresp  = (x.kind == K_ERR && j >= ndata - 2) ? 2'b01 : 2'b00;
      hrdata = (j == ndata - 1) ? x.rdata : $urandom;
      @(negedge hclk);
    end
    exp_err[x.who] = (x.kind != K_OK);
    if (x.kind != K_HANG && !x.wr) exp_rdata[x.who] = x.rdata;
    check("done",      32'({done1, done0}), x.who ? 32'd2 : 32'd1);
    check("err0",      32'(err0), 32'(exp_err[0]));
    check("err1",      32'(err1), 32'(exp_err[1]));
    check("rdata0",    rdata0, exp_rdata[0]);
    check("rdata1",    rdata1, exp_rdata[1]);
    check("done_busy", 32'({busy, hsel}), 32'h0);
    hready = 1'b1;
    hresp  = 2'b00;
  endtask

  // Serves everything queued in xq0/xq1; each requester holds req until its
  // last queued access completes. Service order comes from the arbitration rule.
  task automatic run_batch();
    bit    order[$];
    int    n0, n1;
    bit    lg, w, more;
    xfer_t x;
    n0 = xq0.size();
    n1 = xq1.size();
    lg = last_grant;
    while (n0 + n1 > 0) begin
      w = (n0 > 0 && n1 > 0) ? ~lg : (n1 > 0);
      order.push_back(w);
      lg = w;
      if (w) n1--; else n0--;
    end
    last_grant = lg;
    if (xq0.size() > 0) begin req0 = 1'b1; set_fields(1'b0, xq0[0].wr, xq0[0].addr, xq0[0].wdata); end
    if (xq1.size() > 0) begin req1 = 1'b1; set_fields(1'b1, xq1[0].wr, xq1[0].addr, xq1[0].wdata); end
    foreach (order[k]) begin
      x    = order[k] ? xq1.pop_front() : xq0.pop_front();
      more = order[k] ? (xq1.size() > 0) : (xq0.size() > 0);
      run_xfer(x, !more);
      if (more) begin
        if (order[k]) set_fields(1'b1, xq1[0].wr, xq1[0].addr, xq1[0].wdata);
        else          set_fields(1'b0, xq0[0].wr, xq0[0].addr, xq0[0].wdata);
      end else begin
        set_req(order[k], 1'b0);
      end
      @(negedge hclk);
    end
    check("post_done", 32'({done1, done0}), 32'h0);
  endtask

  initial begin
    int w;
    int c0, c1, mode;
    hresetn = 1'b0;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    p_req0 = 1'b0; p_req1 = 1'b0;
    hready = 1'b1; hresp = 2'b00; hrdata = '0;
    last_grant = 1'b1;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    repeat (2) @(negedge hclk);
    check("rst_ctl",   32'({hsel, htrans, hwrite, hmastlock, hburst, busy, grant}), 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwdat", hwdata, 32'h0);
    check("rst_stat",  32'({done0, done1, err0, err1}), 32'h0);
    check("rst_rd0",   rdata0, 32'h0);
    check("rst_rd1",   rdata1, 32'h0);
    check("hsize",     32'(hsize), 32'h2);
    hresetn = 1'b1;

    // Single zero-wait write from requester 0.
    xq0.push_back(mk(1'b0, 1'b1, 32'h300, 32'h1, 32'h0, 0, 0, K_OK));
    run_batch();
    // Read with two data wait states from requester 1.
    xq1.push_back(mk(1'b1, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 0, 2, K_OK));
    run_batch();
    // Both held for four transfers: grants alternate 0,1,0,1.
    for (int i = 0; i < 2; i++) begin
      xq0.push_back(mk(1'b0, 1'b1, 32'h400 + 32'(i), 32'hA0 + 32'(i), 32'h0, 0, 0, K_OK));
      xq1.push_back(mk(1'b1, 1'b0, 32'h500 + 32'(i), 32'h0, 32'hB0 + 32'(i), 0, 0, K_OK));
    end
    run_batch();
    // Two-cycle ERROR on a write to 0x0, then a normal transfer.
    xq0.push_back(mk(1'b0, 1'b1, 32'h0, 32'h77, 32'h0, 0, 1, K_ERR));
    run_batch();
    xq0.push_back(mk(1'b0, 1'b0, 32'h8, 32'h0, 32'h12345678, 0, 0, K_OK));
    run_batch();
    // Hung slave: abandoned after TO low data cycles.
    xq1.push_back(mk(1'b1, 1'b0, 32'h108, 32'h0, 32'hCAFE, 0, 0, K_HANG));
    run_batch();

    // Fixed priority instance: requester 0 wins every time.
    p_req0 = 1'b1;
    p_req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!(p_done0 || p_done1) && w < 12) begin
        @(negedge hclk);
        w++;
      end
      check("pri_wait",  32'(w < 12), 32'h1);
      check("pri_grant", 32'({p_done1, p_done0, p_grant}), 32'h2);
      @(negedge hclk);
    end
    p_req0 = 1'b0;
    p_req1 = 1'b0;
    repeat (4) @(negedge hclk);

    // Reset asserted during the data phase.
    req0 = 1'b1;
    set_fields(1'b0, 1'b0, 32'h200, 32'h55);
    hready = 1'b1;
    @(negedge hclk);
    check("rst_pre_addr", 32'(hsel), 32'h1);
    @(negedge hclk);
    check("rst_pre_data", 32'({busy, hsel}), 32'h2);
    hready = 1'b0;
    #2;
    hresetn = 1'b0;
    req0 = 1'b0;
    #1;
    check("rst_mid", 32'({hsel, htrans, busy, done1, done0}), 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    hready = 1'b1;
    last_grant = 1'b1;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_err0",   32'(err0), 32'h0);
    @(negedge hclk);
    check("rst_nodone", 32'({busy, done1, done0}), 32'h0);
    xq0.push_back(mk(1'b0, 1'b0, 32'h204, 32'h0, 32'h600DF00D, 0, 1, K_OK));
    run_batch();

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      c0 = (mode != 1) ? int'($urandom_range(1, 2)) : 0;
      c1 = (mode != 0) ? int'($urandom_range(1, 2)) : 0;
      for (int i = 0; i < c0; i++) xq0.push_back(rand_xfer(1'b0));
      for (int i = 0; i < c1; i++) xq1.push_back(rand_xfer(1'b1));
      run_batch();
      repeat (int'($urandom_range(0, 2))) @(negedge hclk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ahb_cfg_arb.md
Name: ahb_cfg_arb

Overview:
- Two-requester arbiter and single-transfer AHB-Lite master that shares the one AHB slave port of the tdm register bank.
- Requester 0 is the configuration writer (bypass, p2tdm and tdm2p enables). Requester 1 is the register poller, regmon-style.
- Serialises their accesses, drives hsel/haddr/htrans/hwrite/hwdata, and returns read data and a completion pulse per access.

Parameters:
- PRIORITY, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 wins.
- TIMEOUT, 256, hclk cycles with hready low in one transfer before it is abandoned with an error; range 2..65535.

Ports:
- hclk  input  1  AHB clock; the only clock.
- hresetn  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 access request; held until done0.
- wr0  input  1  1 = write, 0 = read.
- addr0  input  32  byte address.
- wdata0  input  32  write data.
- done0  output  1  one-cycle completion pulse.
- rdata0  output  32  read data; valid with done0.
- err0  output  1  error status; valid with done0.
- req1, wr1, addr1, wdata1, done1, rdata1, err1: same as the requester 0 signals, for requester 1.
- hsel  output  1  slave select.
- haddr  output  32  address.
- htrans  output  2  00 IDLE / 10 NONSEQ only.
- hwrite  output  1  transfer direction.
- hsize  output  3  constant 3'b010 (word).
- hburst  output  3  constant 3'b000 (SINGLE).
- hmastlock  output  1  constant 0.
- hwdata  output  32  write data.
- hrdata  input  32  read data.
- hready  input  1  slave ready.
- hresp  input  2  00 OKAY, 01 ERROR.
- grant  output  1  index of the current/last granted requester.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0. Reset mid-transfer returns to IDLE at once, without a done pulse. Round-robin pointer resets so requester 0 is favoured first.

FSM IDLE:
- hsel = 0, htrans = 00.
- If req0 or req1 is high, select the winner:
  - PRIORITY = 1: requester 0 if req0.
  - PRIORITY = 0, both requesting: the requester not granted last.
- Latch the winner's wr/addr/wdata, set grant, go to ADDR on the next edge.

FSM ADDR:
- Drive hsel = 1, htrans = 10, haddr and hwrite from the latched values.
- On an edge with hready = 1, go to DATA.

FSM DATA:
- Drive hsel = 0, htrans = 00. hwdata = latched wdata; hwdata holds its value outside DATA.
- On an edge with hready = 1:
  - Pulse done[grant] for one cycle.
  - err[grant] = (hresp != 00).
  - rdata[grant] = hrdata if read, else unchanged.
  - Go to IDLE.

Latency and throughput:
- Zero-wait-state slave: req high at edge N → ADDR at N+1, DATA at N+2, done high during N+3.
- Minimum 4 cycles per access. No address/data pipelining. At least one IDLE cycle between transfers.

Timeout:
- A 16-bit counter clears on entry to ADDR and DATA and increments each cycle with hready = 0.
- When it reaches TIMEOUT-1 with hready still 0: pulse done[grant] with err = 1, rdata unchanged, go to IDLE.

Error response:
- hresp is sampled only when hready = 1. A two-cycle ERROR response therefore reports on its second cycle.

Requester handshake:
- wr/addr/wdata are sampled only on grant; changes after grant are ignored.
- A req dropped before done still completes the transfer and still pulses done.
- A req still high in the cycle after done is treated as a new request.
- The done/err/rdata outputs of the non-granted requester never change.

Other:
- busy = (state != IDLE).
- Both requests simultaneous with reset release: arbitration starts on the first edge after hresetn rises.

Test Plan:
- Single write, zero-wait slave: req0, wr0 = 1, addr0 = 0x300, wdata0 = 0x1 → haddr = 0x300 and htrans = 10 for 1 cycle; hwdata = 0x1 in DATA; done0 3 cycles after grant; err0 = 0.
- Read with 2 wait states: req1, wr1 = 0, addr1 = 0x104, slave hready low 2 cycles, hrdata = 0xDEADBEEF → done1 after 5 cycles, rdata1 = 0xDEADBEEF, done0 never pulses.
- Round-robin, req0 and req1 held high for 4 transfers → grant sequence 0, 1, 0, 1. With PRIORITY = 1 → 0, 0, 0, 0.
- Slave ERROR, two-cycle hresp = 01 on a write to 0x0 → done0 with err0 = 1; next transfer issues normally.
- Hang: TIMEOUT = 8, hready stuck low in DATA → done pulses exactly 8 cycles after DATA entry, err = 1, FSM back in IDLE, busy = 0.
- Reset in DATA: hresetn low for 1 cycle → hsel, htrans, busy and all done outputs 0 immediately, no done pulse; a new req0 after release completes normally.
